// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared command encodings, FSM states and helpers for the SDRAM sequencer
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  localparam int A10_BIT = 10;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF1,
    ST_INIT_REF2,
    ST_INIT_MRS,
    ST_IDLE,
    ST_ACT,
    ST_RW,
    ST_REF
  } seq_state_t;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - free-running refresh interval counter with a single pending flag
module sdram_refresh_timer #(
  parameter int T_REFI = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic ack,
  output logic due,
  output logic pending
);

  localparam int CW = $clog2(T_REFI + 1);

  logic [CW-1:0] cnt;

  assign due = enable && (cnt == CW'(T_REFI - 1));

  // A new expiry wins over a same-cycle ack so no interval is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (!enable || due) cnt <= '0;
      else                cnt <= cnt + CW'(1);
      if (due)      pending <= 1'b1;
      else if (ack) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_cmd_seq.sv
// rtl/sdram_cmd_seq.sv - SDRAM init/refresh/ACT->RD/WR-AP command sequencer (SDRAM_CMD_SEQ_FAST_INIT_EN: 16-cycle power-up wait)
module sdram_cmd_seq
  import sdram_pkg::*;
#(
  parameter int W_ROW    = 13,
  parameter int W_COL    = 10,
  parameter int W_BANK   = 2,
  parameter int T_INIT   = 20000,
  parameter int T_RP     = 3,
  parameter int T_RCD    = 3,
  parameter int T_RFC    = 9,
  parameter int T_MRD    = 2,
  parameter int T_RWDONE = 8,
  parameter int T_REFI   = 780,
  parameter logic [W_ROW-1:0] MODE_REG = 13'h020
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [W_BANK+W_ROW+W_COL-1:0] req_addr,
  output logic                          init_done,
  output logic                          sdram_cke,
  output logic                          sdram_cs_n,
  output logic                          sdram_ras_n,
  output logic                          sdram_cas_n,
  output logic                          sdram_we_n,
  output logic [W_BANK-1:0]             sdram_ba,
  output logic [W_ROW-1:0]              sdram_a
);

`ifdef SDRAM_CMD_SEQ_FAST_INIT_EN
  localparam int INIT_CYCLES = 16;
`else
  localparam int INIT_CYCLES = T_INIT;
`endif

  localparam int T_MAX = max2(max2(max2(INIT_CYCLES, T_RWDONE), max2(T_RFC, T_RCD)),
                              max2(T_RP, T_MRD));
  localparam int TW = $clog2(T_MAX + 1);

  localparam logic [W_ROW-1:0] A_AP = W_ROW'(1 << A10_BIT);

  // Timer is loaded with T-1 so the next command lands exactly T cycles later.
  localparam logic [TW-1:0] LD_RP    = TW'(T_RP - 1);
  localparam logic [TW-1:0] LD_RCD   = TW'(T_RCD - 1);
  localparam logic [TW-1:0] LD_RFC   = TW'(T_RFC - 1);
  localparam logic [TW-1:0] LD_MRD   = TW'(T_MRD - 1);
  localparam logic [TW-1:0] LD_RW    = TW'(T_RWDONE - 1);
  localparam logic [TW-1:0] LD_INIT  = TW'(INIT_CYCLES);

  seq_state_t         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [W_BANK-1:0]  ba_d;
  logic [W_ROW-1:0]   a_d;
  logic [W_COL-1:0]   col_q, col_d;
  logic               wr_q, wr_d;
  logic               init_done_d;
  logic               ready_d;
  logic               ref_ack;
  logic               ref_due;
  logic               ref_pending;
  logic               pending_d;
  logic               timer_zero;

  wire [W_BANK-1:0] req_bank = req_addr[W_BANK+W_ROW+W_COL-1 -: W_BANK];
  wire [W_ROW-1:0]  req_row  = req_addr[W_ROW+W_COL-1 -: W_ROW];
  wire [W_COL-1:0]  req_col  = req_addr[W_COL-1:0];

  sdram_refresh_timer #(
    .T_REFI (T_REFI)
  ) u_refresh_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (init_done),
    .ack     (ref_ack),
    .due     (ref_due),
    .pending (ref_pending)
  );

  assign timer_zero = (timer_q == '0);
  assign pending_d  = ref_due || (ref_pending && !ref_ack);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_zero ? timer_q : timer_q - TW'(1);
    cmd_d       = CMD_NOP;
    ba_d        = sdram_ba;
    a_d         = sdram_a;
    col_d       = col_q;
    wr_d        = wr_q;
    init_done_d = init_done;
    ref_ack     = 1'b0;

    case (state_q)
      ST_INIT_WAIT: if (timer_zero) begin
        cmd_d   = CMD_PRE;
        a_d     = A_AP;
        ba_d    = '0;
        timer_d = LD_RP;
        state_d = ST_INIT_PRE;
      end
      ST_INIT_PRE: if (timer_zero) begin
        cmd_d   = CMD_REF;
        timer_d = LD_RFC;
        state_d = ST_INIT_REF1;
      end
      ST_INIT_REF1: if (timer_zero) begin
        cmd_d   = CMD_REF;
        timer_d = LD_RFC;
        state_d = ST_INIT_REF2;
      end
      ST_INIT_REF2: if (timer_zero) begin
        cmd_d   = CMD_MRS;
        a_d     = MODE_REG;
        ba_d    = '0;
        timer_d = LD_MRD;
        state_d = ST_INIT_MRS;
      end
      ST_INIT_MRS: if (timer_zero) begin
        init_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_IDLE: begin
        // Refresh outranks a waiting request.
        if (ref_pending) begin
          cmd_d   = CMD_REF;
          ref_ack = 1'b1;
          timer_d = LD_RFC;
          state_d = ST_REF;
        end else if (req_valid && req_ready) begin
          cmd_d   = CMD_ACT;
          ba_d    = req_bank;
          a_d     = req_row;
          col_d   = req_col;
          wr_d    = req_write;
          timer_d = LD_RCD;
          state_d = ST_ACT;
        end
      end
      ST_ACT: if (timer_zero) begin
        cmd_d   = wr_q ? CMD_WR : CMD_RD;
        a_d     = A_AP | W_ROW'(col_q);
        timer_d = LD_RW;
        state_d = ST_RW;
      end
      ST_RW, ST_REF: if (timer_zero) begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT_WAIT;
    endcase

    ready_d = (state_d == ST_IDLE) && !pending_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT_WAIT;
      timer_q   <= LD_INIT;
      cmd_q     <= CMD_DESEL;
      sdram_cke <= 1'b0;
      sdram_ba  <= '0;
      sdram_a   <= '0;
      col_q     <= '0;
      wr_q      <= 1'b0;
      init_done <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cmd_q     <= cmd_d;
      sdram_cke <= 1'b1;
      sdram_ba  <= ba_d;
      sdram_a   <= a_d;
      col_q     <= col_d;
      wr_q      <= wr_d;
      init_done <= init_done_d;
      req_ready <= ready_d;
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// tb/tb_sdram_cmd_seq.sv - randomized self-checking bench for sdram_cmd_seq with a schedule-level model
module tb_sdram_cmd_seq;

  localparam int T_INIT_B = 16;
  localparam int T_RP     = 3;
  localparam int T_RCD    = 3;
  localparam int T_RFC    = 9;
  localparam int T_MRD    = 2;
  localparam int T_RWDONE = 8;
  localparam int T_REFI   = 780;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REFC = 4'b0001, MRS = 4'b0000, DESEL = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [24:0] req_addr = '0;
  logic        init_done;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;

  sdram_cmd_seq #(
    .T_INIT (T_INIT_B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .init_done   (init_done),
    .sdram_cke   (sdram_cke),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_ba    (sdram_ba),
    .sdram_a     (sdram_a)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: expected command per cycle index since reset release.
  int          c;
  int          d_cyc;
  int          free_at;
  bit          pending;
  logic [3:0]  ev_cmd  [int];
  logic [12:0] ev_a    [int];
  logic [12:0] ev_mask [int];
  logic [1:0]  ev_ba   [int];
  bit          ev_bchk [int];

  logic [3:0]  s_cmd;
  logic [1:0]  s_ba;
  logic [12:0] s_a;
  logic        s_ready, s_valid, s_init_done;
  int          s_c;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (model cycle %0d): got 0x%0h, expected 0x%0h", name, c, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (model cycle %0d)", name, c);
  endtask

  task automatic add_ev(input int t, input logic [3:0] cmd, input logic [12:0] a,
                        input logic [12:0] mask, input logic [1:0] ba, input bit bchk);
    ev_cmd[t]  = cmd;
    ev_a[t]    = a;
    ev_mask[t] = mask;
    ev_ba[t]   = ba;
    ev_bchk[t] = bchk;
  endtask

  task automatic model_reset();
    int t;
    c = -1;
    pending = 0;
    ev_cmd.delete(); ev_a.delete(); ev_mask.delete(); ev_ba.delete(); ev_bchk.delete();
    t = T_INIT_B + 1;
    add_ev(t, PRE, 13'h0400, 13'h0400, 2'd0, 0);
    t += T_RP;
    add_ev(t, REFC, 13'h0, 13'h0, 2'd0, 0);
    t += T_RFC;
    add_ev(t, REFC, 13'h0, 13'h0, 2'd0, 0);
    t += T_RFC;
    add_ev(t, MRS, 13'h0020, 13'h1fff, 2'd0, 1);
    d_cyc = t + T_MRD;
    free_at = d_cyc;
  endtask

  // Sample at negedge, compare against the model, advance it, return just after the next posedge.
  task automatic step();
    logic [3:0] ecmd;
    bit         rdy, ref_now;
    int         nxt;
    @(negedge clk);
    s_cmd       = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    s_ba        = sdram_ba;
    s_a         = sdram_a;
    s_ready     = req_ready;
    s_valid     = req_valid;
    s_init_done = init_done;
    if (!rst_n) begin
      model_reset();
      s_c = -1;
    end else begin
      c++;
      s_c = c;
      ecmd = ev_cmd.exists(c) ? ev_cmd[c] : ((c == 0) ? DESEL : NOP);
      chk("cmd", s_cmd, ecmd);
      if (ev_cmd.exists(c)) begin
        if (ev_mask[c] != 13'h0) chk("addr", s_a & ev_mask[c], ev_a[c] & ev_mask[c]);
        if (ev_bchk[c]) chk("bank", s_ba, ev_ba[c]);
      end
      chk("cke", sdram_cke, int'(c >= 1));
      chk("init_done", s_init_done, int'(c >= d_cyc));
      rdy = (c >= d_cyc) && (c >= free_at) && !pending;
      chk("req_ready", s_ready, int'(rdy));
      ref_now = 0;
      if (c >= d_cyc && c >= free_at) begin
        if (pending) begin
          add_ev(c + 1, REFC, 13'h0, 13'h0, 2'd0, 0);
          free_at = c + 1 + T_RFC;
          ref_now = 1;
        end else if (req_valid) begin
          add_ev(c + 1, ACT, req_addr[22:10], 13'h1fff, req_addr[24:23], 1);
          add_ev(c + 1 + T_RCD, req_write ? WR : RD, 13'h0400 | {3'b000, req_addr[9:0]},
                 13'h1fff, req_addr[24:23], 1);
          free_at = c + 1 + T_RCD + T_RWDONE;
        end
      end
      nxt = c + 1;
      pending = ((nxt >= d_cyc + T_REFI) && ((nxt - d_cyc) % T_REFI == 0)) || (pending && !ref_now);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(output int t, output logic [3:0] cmd);
    t = -1;
    cmd = NOP;
    for (int i = 0; i < 200; i++) begin
      step();
      if (rst_n && s_cmd != NOP && s_cmd != DESEL) begin
        t = s_c;
        cmd = s_cmd;
        break;
      end
    end
    if (t < 0) fail_timeout("wait_cmd");
  endtask

  task automatic wait_accept(output int n);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (s_valid && s_ready) begin
        n = s_c;
        break;
      end
    end
    if (n < 0) fail_timeout("wait_accept");
  endtask

  task automatic wait_init(input string name, input int exp);
    int t;
    t = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (s_init_done) begin
        t = s_c;
        break;
      end
    end
    if (t < 0) fail_timeout(name);
    else chk(name, t, exp);
  endtask

  task automatic check_init_cmds();
    int t;
    logic [3:0] cmd;
    wait_cmd(t, cmd); chk("init_pre_cycle", t, 17); chk("init_pre_cmd", cmd, 4'b0010);
    chk("init_pre_a10", int'(s_a[10]), 1);
    wait_cmd(t, cmd); chk("init_ref1_cycle", t, 20); chk("init_ref1_cmd", cmd, 4'b0001);
    wait_cmd(t, cmd); chk("init_ref2_cycle", t, 29); chk("init_ref2_cmd", cmd, 4'b0001);
    wait_cmd(t, cmd); chk("init_mrs_cycle", t, 38); chk("init_mrs_cmd", cmd, 4'b0000);
    chk("init_mrs_a", s_a, 13'h020);
    wait_init("init_done_cycle", 40);
  endtask

  task automatic single_req(input logic [24:0] addr, input bit wr, input int exp_ba,
                            input int exp_row, input int exp_rwa);
    int n, t;
    logic [3:0] cmd;
    req_addr = addr;
    req_write = wr;
    req_valid = 1'b1;
    wait_accept(n);
    req_valid = 1'b0;
    wait_cmd(t, cmd);
    chk("req_act_cycle", t, n + 1); chk("req_act_cmd", cmd, 4'b0011);
    chk("req_act_ba", s_ba, exp_ba); chk("req_act_row", s_a, exp_row);
    wait_cmd(t, cmd);
    chk("req_rw_cycle", t, n + 4); chk("req_rw_cmd", cmd, wr ? 4'b0100 : 4'b0101);
    chk("req_rw_ba", s_ba, exp_ba); chk("req_rw_a", s_a, exp_rwa);
    t = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (s_ready) begin
        t = s_c;
        break;
      end
    end
    if (t < 0) fail_timeout("req_ready_return");
    else chk("req_ready_return", t, n + 12);
  endtask

  initial begin
    int n [4];
    int t, r_cyc, a_cyc;
    logic [3:0] cmd;
    logic [12:0] row;
    logic [9:0]  col;

    repeat (3) step();
    chk("rst_cke", sdram_cke, 0);
    chk("rst_cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 4'hf);
    chk("rst_ba", sdram_ba, 0);
    chk("rst_a", sdram_a, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);
    rst_n = 1'b1;

    check_init_cmds();

    single_req({2'd1, 13'h0abc, 10'h155}, 1'b0, 1, 13'h0abc, 13'h0555);
    row = 13'($urandom);
    col = 10'($urandom);
    single_req({2'd2, row, col}, 1'b1, 2, row, 13'h0400 | {3'b000, col});

    // Back-to-back with req_valid held high.
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr = 25'($urandom);
      req_write = 1'($urandom);
      wait_accept(n[k]);
    end
    req_valid = 1'b0;
    for (int k = 1; k < 4; k++) chk("b2b_spacing", n[k] - n[k-1], 12);

    // Refresh expiry while a request stream is waiting.
    while (c < 790) step();
    req_addr = 25'($urandom);
    req_valid = 1'b1;
    r_cyc = -1;
    a_cyc = -1;
    for (int i = 0; i < 120; i++) begin
      step();
      if (s_cmd == REFC && r_cyc < 0) r_cyc = s_c;
      else if (r_cyc >= 0 && s_cmd == ACT) begin
        a_cyc = s_c;
        break;
      end
    end
    req_valid = 1'b0;
    if (a_cyc < 0) fail_timeout("refresh_then_act");
    else chk("refresh_then_act", a_cyc - r_cyc, 10);

    for (int i = 0; i < 1600; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_write = 1'($urandom);
      req_addr = 25'($urandom);
      step();
    end
    req_valid = 1'b0;

    // Reset during the RW wait.
    req_addr = 25'($urandom);
    req_valid = 1'b1;
    wait_accept(t);
    req_valid = 1'b0;
    cmd = NOP;
    for (int i = 0; i < 4 && cmd != RD && cmd != WR; i++) wait_cmd(t, cmd);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cke", sdram_cke, 0);
    chk("midrst_cmd", {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 4'hf);
    chk("midrst_ba", sdram_ba, 0);
    chk("midrst_a", sdram_a, 0);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_init_done", init_done, 0);
    repeat (3) step();
    rst_n = 1'b1;
    check_init_cmds();

    for (int i = 0; i < 200; i++) begin
      req_valid = ($urandom_range(0, 1) == 0);
      req_write = 1'($urandom);
      req_addr = 25'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_seq.md
Name: sdram_cmd_seq

Overview:
- SDRAM command sequencer: power-up init, periodic auto-refresh, single-beat read/write requests converted to ACTIVATE → READ/WRITE-with-auto-precharge.
- Drives raw SDRAM command/address signals that feed the per-pin IO output registers (address, bank and command buffers) immediately downstream.
- Data path (DQ, DQM, read capture) is out of scope; the sequencer only schedules commands.

Parameters:
- W_ROW, 13, row address width
- W_COL, 10, column address width (must be ≤ 10 so A10 stays free for auto-precharge)
- W_BANK, 2, bank address width
- T_INIT, 20000, power-up NOP wait in clk cycles
- T_RP, 3, precharge-to-next-command cycles
- T_RCD, 3, ACTIVATE-to-READ/WRITE cycles
- T_RFC, 9, REFRESH-to-next-command cycles
- T_MRD, 2, MRS-to-next-command cycles
- T_RWDONE, 8, READ/WRITE-to-IDLE cycles (covers CL, burst, tWR and tRP)
- T_REFI, 780, refresh interval in cycles
- MODE_REG, 13'h020, value driven on A during MRS (CL2, burst length 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer accepts request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  W_BANK+W_ROW+W_COL  address, packed as {bank,row,col}
- init_done  out  1  init sequence complete (sticky until reset)
- sdram_cke  out  1  clock enable
- sdram_cs_n  out  1  chip select
- sdram_ras_n  out  1  row address strobe
- sdram_cas_n  out  1  column address strobe
- sdram_we_n  out  1  write enable
- sdram_ba  out  W_BANK  bank address
- sdram_a  out  W_ROW  address bus

Behaviour:
- Reset and clocking: rst_n is asynchronous, active-low; all logic is on clk. All outputs are registered.
- Reset values: cke=0, cs_n/ras_n/cas_n/we_n=1 (DESELECT), ba=0, a=0, req_ready=0, init_done=0, timer=T_INIT.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP=0111, ACT=0011, RD=0101, WR=0100, PRE=0010, REF=0001, MRS=0000
  - Every command is a 1-cycle pulse; all other cycles are NOP.
- Single down-counter timer. A wait of T means the next command appears exactly T cycles after the previous one.
- FSM states: INIT_WAIT → INIT_PRE → INIT_REF1 → INIT_REF2 → INIT_MRS → IDLE; IDLE → ACT → RW → IDLE; IDLE → REF → IDLE.
- Init sequence:
  - First cycle after reset release: cke=1. NOP for T_INIT cycles.
  - PRE with a[10]=1 (all banks); wait T_RP.
  - REF; wait T_RFC. REF; wait T_RFC.
  - MRS with a=MODE_REG, ba=0; wait T_MRD.
  - init_done=1 on entry to IDLE.
- Refresh timer:
  - Starts counting at init_done; sets refresh_pending every T_REFI cycles.
  - pending is a single flag. A second expiry while pending is set is absorbed (no counting).
  - pending clears when REF is issued.
- req_ready=1 only in IDLE with timer expired and refresh_pending=0. If pending and a request arrive together, REF wins and the request waits.
- Request accept at the edge of cycle N (req_valid & req_ready):
  - Address and direction are latched.
  - N+1: ACT, ba=bank, a=row.
  - N+1+T_RCD: RD or WR, a={a[12:11]=0, a[10]=1, col zero-extended}.
  - IDLE is re-entered T_RWDONE cycles later; req_ready is high in that cycle if no refresh is pending.
- req_ready is low in every state other than IDLE. req_addr is ignored while req_valid is low.
- Reset asserted mid-operation: immediate return to reset values; the full init sequence reruns.

Optional Feature:
- Macro SDRAM_CMD_SEQ_FAST_INIT_EN.
- Defined: T_INIT wait replaced by 16 cycles (simulation speed-up); all other timing unchanged.
- Undefined: full T_INIT wait.

Decomposition:
- Shared package sdram_pkg:
  - 4-bit command encodings (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_DESEL)
  - FSM state enum
  - A10 auto-precharge bit index constant
- Sub-module sdram_refresh_timer: T_REFI counter plus pending flag, with inputs enable (=init_done) and ack (=REF issued).

Test Plan:
- Reset release with FAST_INIT_EN → 16 NOP cycles, then PRE (a[10]=1), REF 3 cycles later, REF 9 cycles later, MRS (a=13'h020) 9 cycles later, init_done 2 cycles after MRS.
- Read at req_addr={2'd1,13'h0abc,10'h155}, accepted at cycle N → ACT ba=1 a=0abc at N+1; RD ba=1 a=0x555 at N+4; req_ready=1 again at N+12.
- Write request → WR (0100) at N+4 with a[10]=1; ras/cas/we match WR encoding; no other non-NOP command until IDLE.
- Refresh expiry with req_valid held high → REF issued first; req_ready low until 9 cycles after REF; request then accepted.
- Back-to-back: 4 requests with req_valid held high → each ACT spaced exactly 1+T_RCD+T_RWDONE=12 cycles apart; no command overlap.
- rst_n asserted during the RW wait → outputs reset asynchronously to DESELECT with cke=0; init sequence restarts from INIT_WAIT after release.
